// File: rtl/ifu_itcm_lockstep_arb.sv
// Shares one ITCM fetch port between two IFUs: round-robin in split mode, merged fetches in lockstep mode.
// Zero-latency command/response paths; an owner-mask FIFO routes in-order responses back to their cores.
module ifu_itcm_lockstep_arb #(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int OUTS_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lockstep_en,
    input  logic          c0_cmd_valid,
    output logic          c0_cmd_ready,
    input  logic [AW-1:0] c0_cmd_addr,
    output logic          c0_rsp_valid,
    input  logic          c0_rsp_ready,
    output logic          c0_rsp_err,
    output logic [DW-1:0] c0_rsp_rdata,
    input  logic          c1_cmd_valid,
    output logic          c1_cmd_ready,
    input  logic [AW-1:0] c1_cmd_addr,
    output logic          c1_rsp_valid,
    input  logic          c1_rsp_ready,
    output logic          c1_rsp_err,
    output logic [DW-1:0] c1_rsp_rdata,
    output logic          itcm_cmd_valid,
    input  logic          itcm_cmd_ready,
    output logic [AW-1:0] itcm_cmd_addr,
    input  logic          itcm_rsp_valid,
    output logic          itcm_rsp_ready,
    input  logic          itcm_rsp_err,
    input  logic [DW-1:0] itcm_rsp_rdata,
    output logic          lockstep_mode,
    output logic          fetch_mismatch,
    output logic          arb_idle
);
    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH) + 1;

    logic [1:0]    tag_q [OUTS_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mis_q, rr_q;

    logic          empty, full, gnt_c1, both_vld, addr_eq, mis_set;
    logic          cmd_vld, c0_rdy, c1_rdy, cmd_hs, rsp_rdy, pop;
    logic [1:0]    push_mask, head;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(OUTS_DEPTH));
    assign head     = tag_q[rd_ptr_q];
    assign both_vld = c0_cmd_valid & c1_cmd_valid;
    assign addr_eq  = (c0_cmd_addr == c1_cmd_addr);
    assign gnt_c1   = c1_cmd_valid & (~c0_cmd_valid | rr_q);
    assign mis_set  = mode_q & both_vld & ~addr_eq;

    always_comb begin
        cmd_vld   = 1'b0;
        c0_rdy    = 1'b0;
        c1_rdy    = 1'b0;
        push_mask = 2'b00;
        if (mode_q) begin
            cmd_vld   = both_vld & addr_eq & ~full & ~mis_q;
            c0_rdy    = cmd_vld & itcm_cmd_ready;
            c1_rdy    = cmd_vld & itcm_cmd_ready;
            push_mask = 2'b11;
        end else begin
            // A latched mismatch keeps the fetch port frozen even after leaving lockstep.
            cmd_vld   = (c0_cmd_valid | c1_cmd_valid) & ~full & ~mis_q;
            c0_rdy    = ~gnt_c1 & itcm_cmd_ready & ~full & ~mis_q;
            c1_rdy    =  gnt_c1 & itcm_cmd_ready & ~full & ~mis_q;
            push_mask = gnt_c1 ? 2'b10 : 2'b01;
        end
    end

    assign cmd_hs  = cmd_vld & itcm_cmd_ready;
    // An unexpected beat with nothing outstanding is accepted and dropped.
    assign rsp_rdy = empty | ((~head[0] | c0_rsp_ready) & (~head[1] | c1_rsp_ready));
    assign pop     = itcm_rsp_valid & rsp_rdy & ~empty;
    assign cnt_d   = cnt_q + CW'(cmd_hs) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUTS_DEPTH; i++) tag_q[i] <= 2'b00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            mis_q    <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            if (cmd_hs) begin
                tag_q[wr_ptr_q] <= push_mask;
                wr_ptr_q        <= (wr_ptr_q == PW'(OUTS_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                if (!mode_q) rr_q <= ~gnt_c1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == PW'(OUTS_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            if (empty && !cmd_hs) mode_q <= lockstep_en;
            if (mis_set) mis_q <= 1'b1;
        end
    end

    assign itcm_cmd_valid = cmd_vld & ~rst;
    assign itcm_cmd_addr  = (!mode_q && gnt_c1) ? c1_cmd_addr : c0_cmd_addr;
    assign c0_cmd_ready   = c0_rdy & ~rst;
    assign c1_cmd_ready   = c1_rdy & ~rst;
    assign c0_rsp_valid   = itcm_rsp_valid & ~empty & head[0] & ~rst;
    assign c1_rsp_valid   = itcm_rsp_valid & ~empty & head[1] & ~rst;
    assign c0_rsp_err     = itcm_rsp_err;
    assign c1_rsp_err     = itcm_rsp_err;
    assign c0_rsp_rdata   = itcm_rsp_rdata;
    assign c1_rsp_rdata   = itcm_rsp_rdata;
    assign itcm_rsp_ready = rsp_rdy & ~rst;
    assign lockstep_mode  = mode_q;
    assign fetch_mismatch = mis_q;
    assign arb_idle       = empty;
endmodule

// File: tb/tb_ifu_itcm_lockstep_arb.sv
// Directed bench for ifu_itcm_lockstep_arb with hand-computed expectations.
module tb_ifu_itcm_lockstep_arb;
    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          lockstep_en;
    logic          c0_cmd_valid, c0_cmd_ready, c0_rsp_valid, c0_rsp_ready, c0_rsp_err;
    logic          c1_cmd_valid, c1_cmd_ready, c1_rsp_valid, c1_rsp_ready, c1_rsp_err;
    logic [AW-1:0] c0_cmd_addr, c1_cmd_addr, itcm_cmd_addr;
    logic [DW-1:0] c0_rsp_rdata, c1_rsp_rdata, itcm_rsp_rdata;
    logic          itcm_cmd_valid, itcm_cmd_ready, itcm_rsp_valid, itcm_rsp_ready, itcm_rsp_err;
    logic          lockstep_mode, fetch_mismatch, arb_idle;

    int n_chk = 0;
    int n_err = 0;

    ifu_itcm_lockstep_arb #(.AW(AW), .DW(DW), .OUTS_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .lockstep_en(lockstep_en),
        .c0_cmd_valid(c0_cmd_valid), .c0_cmd_ready(c0_cmd_ready), .c0_cmd_addr(c0_cmd_addr),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_ready(c0_rsp_ready), .c0_rsp_err(c0_rsp_err),
        .c0_rsp_rdata(c0_rsp_rdata),
        .c1_cmd_valid(c1_cmd_valid), .c1_cmd_ready(c1_cmd_ready), .c1_cmd_addr(c1_cmd_addr),
        .c1_rsp_valid(c1_rsp_valid), .c1_rsp_ready(c1_rsp_ready), .c1_rsp_err(c1_rsp_err),
        .c1_rsp_rdata(c1_rsp_rdata),
        .itcm_cmd_valid(itcm_cmd_valid), .itcm_cmd_ready(itcm_cmd_ready), .itcm_cmd_addr(itcm_cmd_addr),
        .itcm_rsp_valid(itcm_rsp_valid), .itcm_rsp_ready(itcm_rsp_ready), .itcm_rsp_err(itcm_rsp_err),
        .itcm_rsp_rdata(itcm_rsp_rdata),
        .lockstep_mode(lockstep_mode), .fetch_mismatch(fetch_mismatch), .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_cmd_valid = 0; c1_cmd_valid = 0; c0_cmd_addr = '0; c1_cmd_addr = '0;
        c0_rsp_ready = 0; c1_rsp_ready = 0; itcm_cmd_ready = 0;
        itcm_rsp_valid = 0; itcm_rsp_err = 0; itcm_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        step();
        rst = 0;
    endtask

    initial begin
        // Reset with active-looking inputs: handshake outputs must stay low.
        rst = 1; lockstep_en = 0;
        idle_inputs();
        c0_cmd_valid = 1; c0_cmd_addr = 16'h0100; itcm_cmd_ready = 1;
        itcm_rsp_valid = 1; c0_rsp_ready = 1;
        #2;
        chk("rst_cmd_valid", itcm_cmd_valid, 0);
        chk("rst_c0_cmd_ready", c0_cmd_ready, 0);
        chk("rst_itcm_rsp_ready", itcm_rsp_ready, 0);
        chk("rst_c0_rsp_valid", c0_rsp_valid, 0);
        chk("rst_mode", lockstep_mode, 0);
        chk("rst_mismatch", fetch_mismatch, 0);
        chk("rst_idle", arb_idle, 1);
        idle_inputs();
        step();
        rst = 0;

        // 1: split, c0 alone
        c0_cmd_valid = 1; c0_cmd_addr = 16'h0100; itcm_cmd_ready = 1;
        @(negedge clk);
        chk("t1_cmd_valid", itcm_cmd_valid, 1);
        chk("t1_cmd_addr", itcm_cmd_addr, 16'h0100);
        chk("t1_c0_rdy", c0_cmd_ready, 1);
        chk("t1_c1_rdy", c1_cmd_ready, 0);
        step();
        c0_cmd_valid = 0;
        itcm_rsp_valid = 1; itcm_rsp_rdata = 64'hDEAD; c0_rsp_ready = 1; c1_rsp_ready = 1;
        @(negedge clk);
        chk("t1_busy", arb_idle, 0);
        chk("t1_c0_rsp_valid", c0_rsp_valid, 1);
        chk("t1_c1_rsp_valid", c1_rsp_valid, 0);
        chk("t1_c0_rdata", c0_rsp_rdata, 64'hDEAD);
        chk("t1_rsp_ready", itcm_rsp_ready, 1);
        step();
        itcm_rsp_valid = 0;
        @(negedge clk);
        chk("t1_idle", arb_idle, 1);

        // 2+3: both requesters, round robin, full FIFO stall
        do_reset();
        c0_cmd_valid = 1; c0_cmd_addr = 16'h0200;
        c1_cmd_valid = 1; c1_cmd_addr = 16'h0300;
        itcm_cmd_ready = 1; c0_rsp_ready = 1; c1_rsp_ready = 1;
        @(negedge clk);
        chk("t2_a_addr", itcm_cmd_addr, 16'h0200);
        chk("t2_a_c0_rdy", c0_cmd_ready, 1);
        chk("t2_a_c1_rdy", c1_cmd_ready, 0);
        step();
        @(negedge clk);
        chk("t2_b_addr", itcm_cmd_addr, 16'h0300);
        chk("t2_b_c1_rdy", c1_cmd_ready, 1);
        chk("t2_b_c0_rdy", c0_cmd_ready, 0);
        step();
        @(negedge clk);
        chk("t3_full_cmd_valid", itcm_cmd_valid, 0);
        chk("t3_full_c0_rdy", c0_cmd_ready, 0);
        step();
        itcm_rsp_valid = 1; itcm_rsp_rdata = 64'h11;
        @(negedge clk);
        chk("t3_pop_still_full", itcm_cmd_valid, 0);
        chk("t2_r1_c0_valid", c0_rsp_valid, 1);
        chk("t2_r1_c1_valid", c1_rsp_valid, 0);
        chk("t2_r1_c0_rdata", c0_rsp_rdata, 64'h11);
        step();
        itcm_rsp_rdata = 64'h22;
        @(negedge clk);
        chk("t2_r2_c1_valid", c1_rsp_valid, 1);
        chk("t2_r2_c0_valid", c0_rsp_valid, 0);
        chk("t2_c_cmd_valid", itcm_cmd_valid, 1);
        chk("t2_c_addr", itcm_cmd_addr, 16'h0200);
        step();
        itcm_rsp_rdata = 64'h33;
        @(negedge clk);
        chk("t2_d_addr", itcm_cmd_addr, 16'h0300);
        chk("t2_r3_c0_valid", c0_rsp_valid, 1);
        chk("t2_r3_c1_valid", c1_rsp_valid, 0);
        step();
        c0_cmd_valid = 0; c1_cmd_valid = 0; itcm_rsp_rdata = 64'h44;
        @(negedge clk);
        chk("t2_r4_c1_valid", c1_rsp_valid, 1);
        chk("t2_r4_c0_valid", c0_rsp_valid, 0);
        chk("t2_r4_c1_rdata", c1_rsp_rdata, 64'h44);
        step();
        itcm_rsp_valid = 0;
        @(negedge clk);
        chk("t2_idle", arb_idle, 1);

        // 4: lockstep merge and broadcast
        lockstep_en = 1;
        step();
        @(negedge clk);
        chk("t4_mode", lockstep_mode, 1);
        c0_cmd_valid = 1; c0_cmd_addr = 16'h0040;
        @(negedge clk);
        chk("t4_one_core_wait", itcm_cmd_valid, 0);
        chk("t4_one_core_rdy", c0_cmd_ready, 0);
        step();
        c1_cmd_valid = 1; c1_cmd_addr = 16'h0040;
        @(negedge clk);
        chk("t4_cmd_valid", itcm_cmd_valid, 1);
        chk("t4_cmd_addr", itcm_cmd_addr, 16'h0040);
        chk("t4_c0_rdy", c0_cmd_ready, 1);
        chk("t4_c1_rdy", c1_cmd_ready, 1);
        step();
        c0_cmd_valid = 0; c1_cmd_valid = 0;
        itcm_rsp_valid = 1; itcm_rsp_rdata = 64'hBEEF; itcm_rsp_err = 1;
        c0_rsp_ready = 1; c1_rsp_ready = 0;
        @(negedge clk);
        chk("t4_single_cmd", itcm_cmd_valid, 0);
        chk("t4_c0_rsp_valid", c0_rsp_valid, 1);
        chk("t4_c1_rsp_valid", c1_rsp_valid, 1);
        chk("t4_c1_rdata", c1_rsp_rdata, 64'hBEEF);
        chk("t4_c1_err", c1_rsp_err, 1);
        chk("t4_rsp_wait", itcm_rsp_ready, 0);
        step();
        c1_rsp_ready = 1;
        @(negedge clk);
        chk("t4_rsp_ready", itcm_rsp_ready, 1);
        step();
        itcm_rsp_valid = 0; itcm_rsp_err = 0;
        @(negedge clk);
        chk("t4_idle", arb_idle, 1);

        // 6: mode change deferred until drained, then reset mid-response
        c0_cmd_valid = 1; c1_cmd_valid = 1; c0_cmd_addr = 16'h0080; c1_cmd_addr = 16'h0080;
        step();
        c0_cmd_valid = 0; c1_cmd_valid = 0; lockstep_en = 0;
        step();
        @(negedge clk);
        chk("t6_mode_held", lockstep_mode, 1);
        itcm_rsp_valid = 1;
        step();
        itcm_rsp_valid = 0;
        @(negedge clk);
        chk("t6_mode_held_pop", lockstep_mode, 1);
        step();
        @(negedge clk);
        chk("t6_mode_switched", lockstep_mode, 0);
        c0_cmd_valid = 1; c0_cmd_addr = 16'h0100;
        step();
        c0_cmd_valid = 0; itcm_rsp_valid = 1;
        @(negedge clk);
        chk("t6_outstanding", c0_rsp_valid, 1);
        #1 rst = 1;
        #1;
        chk("t6_rst_c0_rsp_valid", c0_rsp_valid, 0);
        chk("t6_rst_rsp_ready", itcm_rsp_ready, 0);
        chk("t6_rst_idle", arb_idle, 1);
        idle_inputs();
        step();
        rst = 0;

        // 5: lockstep divergence
        lockstep_en = 1;
        step();
        c0_cmd_valid = 1; c0_cmd_addr = 16'h0040;
        c1_cmd_valid = 1; c1_cmd_addr = 16'h0044; itcm_cmd_ready = 1;
        @(negedge clk);
        chk("t5_no_cmd", itcm_cmd_valid, 0);
        chk("t5_c0_rdy", c0_cmd_ready, 0);
        step();
        c1_cmd_addr = 16'h0040;
        @(negedge clk);
        chk("t5_mismatch", fetch_mismatch, 1);
        chk("t5_stall", itcm_cmd_valid, 0);
        step();
        step();
        @(negedge clk);
        chk("t5_sticky", fetch_mismatch, 1);
        do_reset();
        @(negedge clk);
        chk("t5_cleared", fetch_mismatch, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
